// File: rtl/de0qsys_pio_edge_irq.sv
// Edge-capturing PIO with an Avalon-MM slave interface.
// Per-channel path: 2-flop synchronizer -> optional debounce filter ->
// edge detector -> sticky edge_capture.
// Register map: 0 filtered inputs, 1 raw synchronized inputs,
// 2 irq_mask, 3 edge_capture (write-1-to-clear).
// The interrupt is the OR of masked capture bits and is built only from
// register outputs.
module de0qsys_pio_edge_irq #(
  parameter int unsigned       WIDTH           = 10,
  parameter int unsigned       DEBOUNCE_CYCLES = 0,
  parameter int unsigned       EDGE_TYPE       = 0,
  parameter logic [WIDTH-1:0]  IRQ_MASK_RESET  = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [WIDTH-1:0]  in_port,
  output logic              irq
);

  typedef enum logic [1:0] {
    ADDR_FILT = 2'd0,
    ADDR_RAW  = 2'd1,
    ADDR_MASK = 2'd2,
    ADDR_EDGE = 2'd3
  } reg_addr_e;

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] edge_ev;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [31:0]      rd_q, rd_d;
  logic [WIDTH-1:0] clr_bits;
  logic             wr_en;
  reg_addr_e        addr_e;
  logic             unused_wd;

  // Writedata bits above WIDTH have no destination.
  assign unused_wd = ^writedata;

  // Two-flop synchronizer for the asynchronous inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= in_port;
      s2_q <= s1_q;
    end
  end

  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    assign filt = s2_q;
  end else begin : g_debounce
    localparam int unsigned     CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] filt_q, filt_d;

    // The counter holds the number of earlier consecutive differing edges,
    // so reaching LAST on a differing edge means this is the Nth one: load
    // filt now. It therefore never exceeds LAST and cannot wrap.
    always_comb begin
      filt_d = filt_q;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_d[i] = cnt_q[i];
        if (s2_q[i] == filt_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] >= LAST) begin
          filt_d[i] = s2_q[i];
          cnt_d[i]  = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end

    // Filter state registers.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        filt_q <= '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
          cnt_q[i] <= '0;
        end
      end else begin
        filt_q <= filt_d;
        for (int unsigned i = 0; i < WIDTH; i++) begin
          cnt_q[i] <= cnt_d[i];
        end
      end
    end

    assign filt = filt_q;
  end

  // Edge event selection by the configured polarity.
  always_comb begin
    if (EDGE_TYPE == 1) begin
      edge_ev = filt & ~prev_q;
    end else if (EDGE_TYPE == 2) begin
      edge_ev = ~filt & prev_q;
    end else begin
      edge_ev = filt ^ prev_q;
    end
  end

  assign wr_en  = chipselect & ~write_n;
  assign addr_e = reg_addr_e'(address);

  // Capture/mask next-state and read mux; a new event overrides a clear.
  always_comb begin
    clr_bits = '0;
    mask_d   = mask_q;
    rd_d     = '0;
    if (wr_en && addr_e == ADDR_EDGE) begin
      clr_bits = writedata[WIDTH-1:0];
    end
    if (wr_en && addr_e == ADDR_MASK) begin
      mask_d = writedata[WIDTH-1:0];
    end
    edge_d = (edge_q & ~clr_bits) | edge_ev;
    case (addr_e)
      ADDR_FILT: rd_d[WIDTH-1:0] = filt;
      ADDR_RAW:  rd_d[WIDTH-1:0] = s2_q;
      ADDR_MASK: rd_d[WIDTH-1:0] = mask_q;
      ADDR_EDGE: rd_d[WIDTH-1:0] = edge_q;
      default:   rd_d            = '0;
    endcase
  end

  // Edge history, capture, mask and read data registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= '0;
      edge_q <= '0;
      mask_q <= IRQ_MASK_RESET;
      rd_q   <= '0;
    end else begin
      prev_q <= filt;
      edge_q <= edge_d;
      mask_q <= mask_d;
      rd_q   <= rd_d;
    end
  end

  assign readdata = rd_q;
  assign irq      = |(edge_q & mask_q);

endmodule

// File: tb/tb_de0qsys_pio_edge_irq.sv
// Bench for de0qsys_pio_edge_irq: two instances sharing stimulus
// (dut0: no debounce, any edge; dut1: 4-cycle debounce, rising only),
// a directed vector table, hand sequences for latency/override/reset,
// and a randomized phase checked against a window-based reference model.
module tb_de0qsys_pio_edge_irq;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [9:0]  in_port;
  logic [31:0] rd0, rd1;
  logic        irq0, irq1;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  de0qsys_pio_edge_irq #(
    .WIDTH(10), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0), .IRQ_MASK_RESET(10'h000)
  ) dut0 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd0),
    .in_port(in_port), .irq(irq0)
  );

  de0qsys_pio_edge_irq #(
    .WIDTH(10), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1), .IRQ_MASK_RESET(10'h005)
  ) dut1 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd1),
    .in_port(in_port), .irq(irq1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Synchronizer = two-sample delay; dut0 filt is the delayed sample;
  // dut1 filt flips a bit once the last four synchronized samples all
  // disagree with it.
  logic [9:0]  m_s1, m_s2;
  logic [9:0]  m_filt [2];
  logic [9:0]  m_prev [2];
  logic [9:0]  m_cap  [2];
  logic [9:0]  m_mask [2];
  logic [31:0] m_rd   [2];
  logic [9:0]  win[$];

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0;
    for (int p = 0; p < 2; p++) begin
      m_filt[p] = '0; m_prev[p] = '0; m_cap[p] = '0; m_rd[p] = '0;
    end
    m_mask[0] = 10'h000;
    m_mask[1] = 10'h005;
    win.delete();
  endtask

  task automatic model_step();
    logic [9:0] s2b, ev, clr;
    logic       wr, all_diff;
    s2b = m_s2;
    wr  = chipselect && !write_n;
    for (int p = 0; p < 2; p++) begin
      case (address)
        2'd0:    m_rd[p] = {22'd0, m_filt[p]};
        2'd1:    m_rd[p] = {22'd0, s2b};
        2'd2:    m_rd[p] = {22'd0, m_mask[p]};
        default: m_rd[p] = {22'd0, m_cap[p]};
      endcase
      ev  = (p == 0) ? (m_filt[p] ^ m_prev[p]) : (m_filt[p] & ~m_prev[p]);
      clr = (wr && address == 2'd3) ? writedata[9:0] : 10'd0;
      m_cap[p] = (m_cap[p] & ~clr) | ev;
      if (wr && address == 2'd2) m_mask[p] = writedata[9:0];
      m_prev[p] = m_filt[p];
    end
    m_filt[0] = m_s1;
    win.push_back(s2b);
    if (win.size() > 4) void'(win.pop_front());
    if (win.size() == 4) begin
      for (int i = 0; i < 10; i++) begin
        all_diff = 1'b1;
        for (int j = 0; j < 4; j++)
          if (win[j][i] == m_filt[1][i]) all_diff = 1'b0;
        if (all_diff) m_filt[1][i] = ~m_filt[1][i];
      end
    end
    m_s2 = m_s1;
    m_s1 = in_port;
  endtask

  function automatic logic m_irq(input int p);
    return |(m_cap[p] & m_mask[p]);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else       model_step();
  end

  // Continuous comparison against the model, just after each edge.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("model_rd0",  rd0, m_rd[0]);
      chk("model_rd1",  rd1, m_rd[1]);
      chk("model_irq0", {31'd0, irq0}, {31'd0, m_irq(0)});
      chk("model_irq1", {31'd0, irq1}, {31'd0, m_irq(1)});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] a, input logic w, input logic [31:0] d);
    address    = a;
    chipselect = w;
    write_n    = ~w;
    writedata  = d;
  endtask

  typedef struct {
    logic [1:0]  addr;
    logic        wr;
    logic [31:0] wdata;
    logic [9:0]  inp;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t tbl[20];

  initial begin
    // Each row: inputs before an edge, dut0 outputs expected after it.
    tbl[0]  = '{2'd0, 1'b0, 32'h0,        10'h001, 32'h000, 1'b0};
    tbl[1]  = '{2'd0, 1'b0, 32'h0,        10'h001, 32'h000, 1'b0};
    tbl[2]  = '{2'd3, 1'b0, 32'h0,        10'h001, 32'h000, 1'b0};
    tbl[3]  = '{2'd3, 1'b0, 32'h0,        10'h001, 32'h001, 1'b0};
    tbl[4]  = '{2'd0, 1'b0, 32'h0,        10'h001, 32'h001, 1'b0};
    tbl[5]  = '{2'd1, 1'b0, 32'h0,        10'h001, 32'h001, 1'b0};
    tbl[6]  = '{2'd2, 1'b1, 32'hFFFFFFFF, 10'h001, 32'h000, 1'b1};
    tbl[7]  = '{2'd2, 1'b0, 32'h0,        10'h001, 32'h3FF, 1'b1};
    tbl[8]  = '{2'd3, 1'b1, 32'h0,        10'h001, 32'h001, 1'b1};
    tbl[9]  = '{2'd3, 1'b1, 32'hFFFFFC00, 10'h001, 32'h001, 1'b1};
    tbl[10] = '{2'd3, 1'b1, 32'h1,        10'h001, 32'h001, 1'b0};
    tbl[11] = '{2'd3, 1'b0, 32'h0,        10'h001, 32'h000, 1'b0};
    tbl[12] = '{2'd0, 1'b1, 32'h3FF,      10'h001, 32'h001, 1'b0};
    tbl[13] = '{2'd3, 1'b0, 32'h0,        10'h000, 32'h000, 1'b0};
    tbl[14] = '{2'd3, 1'b0, 32'h0,        10'h000, 32'h000, 1'b0};
    tbl[15] = '{2'd3, 1'b0, 32'h0,        10'h000, 32'h000, 1'b1};
    tbl[16] = '{2'd3, 1'b0, 32'h0,        10'h000, 32'h001, 1'b1};
    tbl[17] = '{2'd2, 1'b1, 32'h0,        10'h000, 32'h3FF, 1'b0};
    tbl[18] = '{2'd3, 1'b0, 32'h0,        10'h000, 32'h001, 1'b0};
    tbl[19] = '{2'd2, 1'b1, 32'h1,        10'h000, 32'h000, 1'b1};

    reset   = 1'b1;
    in_port = '0;
    drive(2'd0, 1'b0, 32'h0);
    #2;
    chk("reset_rd0",  rd0, 32'h0);
    chk("reset_irq0", {31'd0, irq0}, 32'h0);
    chk("reset_rd1",  rd1, 32'h0);
    chk("reset_irq1", {31'd0, irq1}, 32'h0);
    repeat (3) tick();
    reset = 1'b0;
    repeat (3) tick();
    chk_en = 1'b1;

    // Directed register-map / latency table.
    foreach (tbl[i]) begin
      drive(tbl[i].addr, tbl[i].wr, tbl[i].wdata);
      in_port = tbl[i].inp;
      tick();
      chk($sformatf("tbl%0d_rd", i), rd0, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_irq", i), {31'd0, irq0}, {31'd0, tbl[i].exp_irq});
    end
    drive(2'd0, 1'b0, 32'h0);

    // Short pulse on bit 3 must not pass the 4-cycle filter.
    repeat (12) tick();
    drive(2'd3, 1'b1, 32'hFFFFFFFF); tick();
    drive(2'd0, 1'b0, 32'h0);
    in_port = 10'h008;
    repeat (3) tick();
    in_port = 10'h000;
    for (int j = 0; j < 10; j++) begin
      tick();
      chk($sformatf("pulse_filt1_%0d", j), rd1 & 32'h8, 32'h0);
    end
    address = 2'd3;
    tick(); tick();
    chk("pulse_cap1", rd1, 32'h0);
    chk("pulse_cap0", rd0, 32'h008);

    // Held input: capture latency N+2 (dut0) and N+6 (dut1).
    repeat (6) tick();
    drive(2'd3, 1'b1, 32'hFFFFFFFF); tick();
    drive(2'd3, 1'b0, 32'h0);
    in_port = 10'h008;
    for (int j = 0; j < 10; j++) begin
      tick();
      chk($sformatf("lat0_%0d", j), rd0 & 32'h8, (j >= 3) ? 32'h8 : 32'h0);
      chk($sformatf("lat1_%0d", j), rd1 & 32'h8, (j >= 7) ? 32'h8 : 32'h0);
    end

    // New event on bit 0 coinciding with its clear: set wins.
    drive(2'd3, 1'b1, 32'hFFFFFFFF); tick();
    drive(2'd3, 1'b0, 32'h0);
    in_port = 10'h00B;
    repeat (3) tick();
    in_port = 10'h00A;
    repeat (2) tick();
    drive(2'd3, 1'b1, 32'h1); tick();
    drive(2'd3, 1'b0, 32'h0); tick();
    chk("setwins_cap", rd0, 32'h003);
    drive(2'd3, 1'b1, 32'h1); tick();
    drive(2'd3, 1'b0, 32'h0); tick();
    chk("w1c_cap", rd0, 32'h002);

    // Unmask a pending bit, then reset asynchronously mid-cycle.
    drive(2'd2, 1'b1, 32'h3FF); tick();
    drive(2'd3, 1'b0, 32'h0);
    chk("unmask_irq0", {31'd0, irq0}, 32'h1);
    #3;
    reset   = 1'b1;
    in_port = 10'h3FF;
    #1;
    chk("async_rd0",  rd0, 32'h0);
    chk("async_irq0", {31'd0, irq0}, 32'h0);
    chk("async_rd1",  rd1, 32'h0);
    chk("async_irq1", {31'd0, irq1}, 32'h0);
    repeat (3) tick();
    reset = 1'b0;
    // Inputs held high through release appear as rising edges.
    for (int j = 0; j < 9; j++) begin
      tick();
      chk($sformatf("rel_rd0_%0d", j), rd0, (j >= 3) ? 32'h3FF : 32'h0);
      chk($sformatf("rel_irq0_%0d", j), {31'd0, irq0}, 32'h0);
      chk($sformatf("rel_rd1_%0d", j), rd1, (j >= 7) ? 32'h3FF : 32'h0);
      chk($sformatf("rel_irq1_%0d", j), {31'd0, irq1}, (j >= 6) ? 32'h1 : 32'h0);
    end

    // Randomized phase, checked by the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 5) == 0)
        in_port = in_port ^ (10'd1 << $urandom_range(0, 9));
      address    = 2'($urandom_range(0, 3));
      chipselect = 1'($urandom_range(0, 1));
      write_n    = ($urandom_range(0, 2) != 0);
      writedata  = $urandom;
      if ($urandom_range(0, 399) == 0) begin
        #3;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
      end
      tick();
    end

    drive(2'd0, 1'b0, 32'h0);
    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
